// File: rtl/branch_pred_sched.sv
// -----------------------------------------------------------------------------
// branch_pred_sched
//
// Branch prediction scheduler. This block sits between fetch, which issues
// lookups, and execute, which issues resolves in program order.
//
// The block holds a table of 2-bit saturating counters. It has 2**IDX_W
// entries, and every entry resets to INIT_STATE.
//   - A lookup reads counter[req_idx]. The lookup is accepted when req_valid
//     and req_ready are both high. On acceptance, {idx, prediction} is pushed
//     into an in-flight FIFO of DEPTH entries. The prediction bit appears on
//     pred_taken one cycle later, qualified by pred_valid.
//   - A resolve pops the FIFO head and trains that counter toward res_taken.
//     One cycle later it pulses mispredict if the stored prediction was wrong.
//     A resolve while the FIFO is empty is ignored and pulses res_err instead.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   lookup request
//   req_idx     in   [IDX_W] lookup index
//   req_ready   out  FIFO has room; a resolve in the same cycle does not help
//   pred_valid  out  registered, high one cycle after an accepted lookup
//   pred_taken  out  registered, counter[idx][1] sampled at acceptance
//   res_valid   in   resolve of the oldest outstanding prediction
//   res_taken   in   actual branch outcome
//   mispredict  out  registered 1-cycle pulse: outcome != stored prediction
//   res_err     out  registered 1-cycle pulse: resolve with an empty FIFO
//   inflight    out  [clog2(DEPTH)+1] current FIFO occupancy
//
// Optional feature: define BPS_STATS_EN to add stat_lookups[15:0] and
// stat_mispred[15:0]. These are saturating counters of accepted lookups and
// of mispredict pulses, and rst_n clears them.
// -----------------------------------------------------------------------------
module branch_pred_sched #(
  parameter int         IDX_W      = 4,
  parameter int         DEPTH      = 4,
  parameter logic [1:0] INIT_STATE = 2'b11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [IDX_W-1:0]         req_idx,
  output logic                     req_ready,
  output logic                     pred_valid,
  output logic                     pred_taken,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     mispredict,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   inflight
`ifdef BPS_STATS_EN
  ,
  output logic [15:0]              stat_lookups,
  output logic [15:0]              stat_mispred
`endif
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  // One outstanding prediction: which counter it came from and what it said.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             pred;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       ctr_q  [ENTRIES];
  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // ---------------------------------------------------------------------------
  // Handshake and datapath decode
  // ---------------------------------------------------------------------------
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       lookup_bit;
  logic       misp_set;
  entry_t     head;
  logic [1:0] head_ctr_next;

  assign fifo_empty = (count_q == '0);

  // Readiness looks only at current occupancy. A resolve in the same cycle
  // frees its slot only from the next cycle, which keeps req_ready registered.
  assign req_ready  = (count_q != CNT_W'(DEPTH));
  assign push       = req_valid & req_ready;
  assign pop        = res_valid & ~fifo_empty;

  // The lookup reads the pre-update table. A lookup and a resolve on the same
  // index in the same cycle therefore see the old counter value, and the
  // training becomes visible from the next cycle.
  assign lookup_bit = ctr_q[req_idx][1];
  assign head       = fifo_q[rd_ptr_q];
  assign misp_set   = pop & (res_taken != head.pred);

  // Saturating 2-bit training of the head entry's counter.
  // NOTE: every variable assigned in always_comb receives a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    head_ctr_next = ctr_q[head.idx];
    if (res_taken) begin
      if (ctr_q[head.idx] != 2'b11) head_ctr_next = ctr_q[head.idx] + 2'd1;
    end else begin
      if (ctr_q[head.idx] != 2'b00) head_ctr_next = ctr_q[head.idx] - 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter table: at most one entry (the resolved head's) changes per cycle.
  // ---------------------------------------------------------------------------
  // NOTE: the counter table is reset because its contents are architecturally
  // visible (every entry must start at INIT_STATE). The FIFO payload below is
  // not reset, because count_q alone decides which slots are valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT_STATE;
    end else if (pop) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the values from before the edge.
      ctr_q[head.idx] <= head_ctr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{idx: req_idx, pred: lookup_bit};
  end

  // DEPTH is a power of two, so the pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign inflight = count_q;

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      mispredict <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      pred_valid <= push;
      pred_taken <= push & lookup_bit;
      mispredict <= misp_set;
      res_err    <= res_valid & fifo_empty;
    end
  end

`ifdef BPS_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else begin
      if (push && stat_lookups != 16'hFFFF)     stat_lookups <= stat_lookups + 16'd1;
      if (misp_set && stat_mispred != 16'hFFFF) stat_mispred <= stat_mispred + 16'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(DEPTH));
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
    (count_q == CNT_W'(DEPTH)) |-> !push);

endmodule

// File: tb/tb_branch_pred_sched.sv
// -----------------------------------------------------------------------------
// tb_branch_pred_sched
//
// Scoreboard bench for branch_pred_sched with the default parameters
// (IDX_W=4, DEPTH=4, INIT_STATE=2'b11).
//
// The bench keeps its own model of the counter table and of the in-flight
// FIFO. Each driven cycle pushes the expected prediction and mispredict
// results into queues. The next cycle pops those queues and compares them
// against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_branch_pred_sched;

  localparam int IDX_W = 4;
  localparam int DEPTH = 4;
  localparam logic [1:0] INIT = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [3:0] req_idx;
  logic       req_ready;
  logic       pred_valid;
  logic       pred_taken;
  logic       res_valid;
  logic       res_taken;
  logic       mispredict;
  logic       res_err;
  logic [2:0] inflight;
`ifdef BPS_STATS_EN
  logic [15:0] stat_lookups;
  logic [15:0] stat_mispred;
`endif

  branch_pred_sched #(.IDX_W(IDX_W), .DEPTH(DEPTH), .INIT_STATE(INIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_idx    (req_idx),
    .req_ready  (req_ready),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .mispredict (mispredict),
    .res_err    (res_err),
    .inflight   (inflight)
`ifdef BPS_STATS_EN
    ,
    .stat_lookups (stat_lookups),
    .stat_mispred (stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Model state and scoreboard queues
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] idx;
    logic       p;
  } m_ent_t;

  logic [1:0] m_ctr [16];
  m_ent_t     m_fifo [$];
  logic       exp_pred_q [$];
  logic       exp_misp_q [$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] train(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = INIT;
    m_fifo.delete();
    exp_pred_q.delete();
    exp_misp_q.delete();
  endtask

  // Drives one clock cycle. The task is entered at posedge+1 and also
  // returns at posedge+1, after the outputs have been checked.
  task automatic cycle(input logic rv, input logic [3:0] ri, input logic sv, input logic st);
    logic   acc, pop, exp_err, look, exp_m;
    m_ent_t h;
    req_valid = rv;
    req_idx   = ri;
    res_valid = sv;
    res_taken = st;
    check("req_ready", req_ready, m_fifo.size() != DEPTH);
    acc     = rv && (m_fifo.size() != DEPTH);
    pop     = sv && (m_fifo.size() != 0);
    exp_err = sv && (m_fifo.size() == 0);
    look    = m_ctr[ri][1];  // read before any training in this cycle
    if (pop) begin
      h = m_fifo.pop_front();
      exp_misp_q.push_back(st != h.p);
      m_ctr[h.idx] = train(m_ctr[h.idx], st);
    end
    if (acc) begin
      m_fifo.push_back('{idx: ri, p: look});
      exp_pred_q.push_back(look);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    res_valid = 1'b0;
    check("pred_valid", pred_valid, acc);
    if (acc && exp_pred_q.size() != 0) check("pred_taken", pred_taken, exp_pred_q.pop_front());
    exp_m = (pop && exp_misp_q.size() != 0) ? exp_misp_q.pop_front() : 1'b0;
    check("mispredict", mispredict, exp_m);
    check("res_err", res_err, exp_err);
    check("inflight", inflight, m_fifo.size());
  endtask

  // Resets the DUT mid-cycle and checks that the outputs clear at once,
  // without waiting for a clock edge.
  task automatic async_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    res_valid = 1'b0;
    #1;
    check("rst_pred_valid", pred_valid, 0);
    check("rst_pred_taken", pred_taken, 0);
    check("rst_mispredict", mispredict, 0);
    check("rst_res_err", res_err, 0);
    check("rst_inflight", inflight, 0);
    check("rst_req_ready", req_ready, 1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Looks up and then resolves (taken) every index. This shows each counter's
  // MSB, and the model then tracks the training that follows.
  task automatic sweep_all();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 4'(i), 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_idx   = '0;
    res_valid = 1'b0;
    res_taken = 1'b0;
    model_reset();
    #12;
    check("init_pred_valid", pred_valid, 0);
    check("init_inflight", inflight, 0);
    check("init_req_ready", req_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Test 1: first lookup predicts taken.
    cycle(1'b1, 4'd3, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b1);

    // Test 2: idx 5 twice, both resolved not-taken, then a third lookup.
    cycle(1'b1, 4'd5, 1'b0, 1'b0);
    cycle(1'b1, 4'd5, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    cycle(1'b1, 4'd5, 1'b0, 1'b0);
    check("t2_pred_not_taken", pred_taken, 0);
    cycle(1'b0, 4'd0, 1'b1, 1'b1);

    // Test 3: fill the FIFO, refuse a fifth lookup (also when a resolve is
    // in the same cycle), then free one slot.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 4'(8 + i), 1'b0, 1'b0);
    check("t3_full_ready", req_ready, 0);
    cycle(1'b1, 4'd1, 1'b0, 1'b0);
    cycle(1'b1, 4'd2, 1'b1, 1'b0);
    check("t3_ready_after_pop", req_ready, 1);
    while (m_fifo.size() != 0) cycle(1'b0, 4'd0, 1'b1, 1'b0);

    // Test 4: resolve with an empty FIFO.
    cycle(1'b0, 4'd0, 1'b1, 1'b1);
    cycle(1'b0, 4'd0, 1'b1, 1'b0);

    // Test 5: bring counter 7 to 01, then do a lookup and a resolve of the
    // same index in one cycle.
    cycle(1'b1, 4'd7, 1'b0, 1'b0);
    cycle(1'b1, 4'd7, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    cycle(1'b1, 4'd7, 1'b0, 1'b0);        // stored p=0, counter at 01
    cycle(1'b1, 4'd7, 1'b1, 1'b1);        // reads old 01, trains to 10
    check("t5_pred_old", pred_taken, 0);
    check("t5_inflight_same", inflight, 1);
    cycle(1'b1, 4'd7, 1'b1, 1'b1);        // now reads 10
    check("t5_pred_new", pred_taken, 1);
    while (m_fifo.size() != 0) cycle(1'b0, 4'd0, 1'b1, 1'b0);

    // Random traffic over a few indices, to exercise pointer wrap and saturation.
    for (int n = 0; n < 300; n++)
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Test 6: reset with 3 in flight while pred_taken is high, then confirm
    // that every counter is back at 11.
    while (m_fifo.size() != 0) cycle(1'b0, 4'd0, 1'b1, 1'b1);
    cycle(1'b1, 4'd12, 1'b0, 1'b0);
    cycle(1'b1, 4'd13, 1'b0, 1'b0);
    cycle(1'b1, 4'd14, 1'b0, 1'b0);
    check("t6_pre_inflight", inflight, 3);
    async_reset();
    sweep_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
